// File: rtl/phv_queue_dispatch_pkg.sv
// Shared constants, types and helpers for the PHV queue dispatcher.
package phv_queue_dispatch_pkg;

  localparam int unsigned DEF_PHV_LEN  = 48*64 + 32*64 + 16*64 + 256;
  localparam int unsigned DEF_QMAP_OFF = 141;
  localparam int unsigned MAX_QUEUES   = 8;

  typedef enum logic {
    EMPTY    = 1'b0,
    DISPATCH = 1'b1
  } disp_state_e;

  // True when two or more bits of the bitmap are set.
  function automatic logic multi_hot(input logic [MAX_QUEUES-1:0] v);
    return (v & (v - MAX_QUEUES'(1))) != '0;
  endfunction

endpackage

// File: rtl/phv_queue_dispatch_if.sv
// PHV handshake bundle: upstream input side plus the shared per-queue output side.
interface phv_queue_dispatch_if #(
  parameter int unsigned PHV_LEN      = phv_queue_dispatch_pkg::DEF_PHV_LEN,
  parameter int unsigned C_NUM_QUEUES = 4
);

  logic [PHV_LEN-1:0]      phv_in;
  logic                    phv_in_valid;
  logic                    phv_in_ready;
  logic [PHV_LEN-1:0]      phv_out;
  logic [C_NUM_QUEUES-1:0] phv_out_valid;
  logic [C_NUM_QUEUES-1:0] phv_fifo_ready;

  modport master (
    output phv_in, phv_in_valid, phv_fifo_ready,
    input  phv_in_ready, phv_out, phv_out_valid
  );

  modport slave (
    input  phv_in, phv_in_valid, phv_fifo_ready,
    output phv_in_ready, phv_out, phv_out_valid
  );

endinterface

// File: rtl/phv_queue_dispatch.sv
// Holds one PHV and fans it out to every queue named in its bitmap; each queue
// completes independently, and a new PHV loads as soon as the last one drains.
module phv_queue_dispatch
  import phv_queue_dispatch_pkg::*;
#(
  parameter int unsigned PHV_LEN      = DEF_PHV_LEN,
  parameter int unsigned C_NUM_QUEUES = 4,
  parameter int unsigned QMAP_OFF     = DEF_QMAP_OFF,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  phv_queue_dispatch_if.slave  bus,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] mcast_cnt
);

  disp_state_e             state_q, state_d;
  logic [C_NUM_QUEUES-1:0] pend_q, pend_d;
  logic [C_NUM_QUEUES-1:0] pend_left;
  logic [C_NUM_QUEUES-1:0] bitmap;
  logic [PHV_LEN-1:0]      hold_q, hold_d;
  logic [CNT_WIDTH-1:0]    drop_q, drop_d;
  logic [CNT_WIDTH-1:0]    mcast_q, mcast_d;
  logic                    in_ready;

  // Queues still owed the held PHV after this cycle's completions.
  assign pend_left = pend_q & ~bus.phv_fifo_ready;
  assign bitmap    = bus.phv_in[QMAP_OFF +: C_NUM_QUEUES];
  assign in_ready  = (state_q == EMPTY) || (pend_left == '0);

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      hold_q  <= '0;
      drop_q  <= '0;
      mcast_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
      mcast_q <= mcast_d;
    end
  end

  always_comb begin
    pend_d  = pend_left;
    hold_d  = hold_q;
    drop_d  = drop_q;
    mcast_d = mcast_q;
    if (bus.phv_in_valid && in_ready) begin
      if (bitmap != '0) begin
        pend_d = bitmap;
        hold_d = bus.phv_in;
        if (multi_hot(MAX_QUEUES'(bitmap)) && (mcast_q != '1)) begin
          mcast_d = mcast_q + CNT_WIDTH'(1);
        end
      end else if (drop_q != '1) begin
        drop_d = drop_q + CNT_WIDTH'(1);
      end
    end
    state_d = (pend_d != '0) ? DISPATCH : EMPTY;
  end

  assign bus.phv_in_ready  = in_ready;
  assign bus.phv_out       = hold_q;
  assign bus.phv_out_valid = pend_q;
  assign drop_cnt          = drop_q;
  assign mcast_cnt         = mcast_q;

endmodule
